// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared fetch-state encoding, bubble encoding and reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register with load / bubble / hold control.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        valid
);

    // Neither load nor bubble means hold; bubbles keep the last PC pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= 32'd0;
            pc4   <= 32'd4;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            pc4   <= pc_in + 32'd4;
            instr <= instr_in;
            valid <= 1'b1;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Fetch PC, single-outstanding imem handshake and IF/ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_buf;
    logic         r_drop;
    logic         r_req_hold;

    logic         w_accept;
    logic         w_load;
    logic         w_bubble;
    logic [31:0]  w_pc4;
    logic [31:0]  w_load_instr;

    // A held request keeps imem_req up even if PCWrite drops.
    assign imem_req  = !reset && (r_state == ST_REQ) && (PCWrite || r_req_hold);
    assign imem_addr = r_fetch_pc;
    assign w_accept  = imem_req && imem_ready;
    assign w_pc4     = r_fetch_pc + 32'd4;

    assign w_load = !reset && !BranchTaken && IF_ID_Write &&
                    (((r_state == ST_WAIT) && imem_rvalid && !r_drop) ||
                     (r_state == ST_HOLD));
    assign w_load_instr = (r_state == ST_HOLD) ? r_buf : imem_rdata;
    assign w_bubble     = !reset && (BranchTaken || (IF_ID_Write && !w_load));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_REQ;
            r_fetch_pc <= RESET_PC;
            r_buf      <= 32'd0;
            r_drop     <= 1'b0;
            r_req_hold <= 1'b0;
        end else if (BranchTaken) begin
            r_fetch_pc <= align_word(BranchTarget);
            r_req_hold <= 1'b0;
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        r_state <= ST_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= ST_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        r_state    <= ST_WAIT;
                        r_req_hold <= 1'b0;
                    end else if (imem_req) begin
                        r_req_hold <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= ST_REQ;
                        end else if (IF_ID_Write) begin
                            r_fetch_pc <= w_pc4;
                            r_state    <= ST_REQ;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (IF_ID_Write) begin
                        r_fetch_pc <= w_pc4;
                        r_state    <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .bubble   (w_bubble),
        .pc_in    (r_fetch_pc),
        .instr_in (w_load_instr),
        .pc       (IF_ID_PC),
        .pc4      (IF_ID_PC4),
        .instr    (IF_ID_Instr),
        .valid    (IF_ID_Valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed step table plus randomized memory/stall scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, PCWrite, IF_ID_Write, BranchTaken;
    logic [31:0] BranchTarget;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_PC, IF_ID_PC4, IF_ID_Instr;
    logic        IF_ID_Valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_PC4    (IF_ID_PC4),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_Valid  (IF_ID_Valid)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, pcw, ifw, br;
        logic [31:0] tgt;
        logic        rdy, rv;
        logic [31:0] rd_addr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, pcw, ifw, br, input logic [31:0] tgt,
                                input logic rdy, rv, input logic [31:0] rd_addr,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.br = br; v.tgt = tgt;
        v.rdy = rdy; v.rv = rv; v.rd_addr = rd_addr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t        tbl[$];
    vec_t        v;

    // Scoreboard state for the random phase
    logic [31:0] exp_pc, m_pc, m_pc4, m_instr, mem_addr, req_addr, prev_addr;
    logic        m_valid, stale, have_buf, mem_busy, acc, prev_pending, rv_now;
    int          mem_lat, kind, deliveries;

    initial begin
        reset = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0; BranchTaken = 1'b0;
        BranchTarget = 32'd0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        //        rst pcw ifw br tgt           rdy rv rd_addr        req addr          val pc
        tbl.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,             0, 0,            0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 0,            0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 1, 0,             0, 0,            1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 32'h4,        0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 1, 32'h4,         0, 0,            1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 32'h8,        0, 32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 1, 32'h8,         0, 0,            0, 32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,             0, 0,            0, 32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0,            1, 0, 0,             0, 0,            0, 32'h4));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             0, 0,            1, 32'h8));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 32'hC,        0, 32'h8));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 1, 32'hC,         0, 0,            1, 32'hC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            0, 0, 0,             1, 32'h10,       0, 32'hC));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0, 0,             1, 32'h10,       0, 32'hC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            0, 0, 0,             1, 32'h10,       0, 32'hC));
        tbl.push_back(mk(0, 0, 1, 0, 0,            0, 0, 0,             1, 32'h10,       0, 32'hC));
        tbl.push_back(mk(0, 0, 1, 0, 0,            1, 0, 0,             1, 32'h10,       0, 32'hC));
        tbl.push_back(mk(0, 1, 1, 1, 32'h103,      1, 0, 0,             0, 0,            0, 32'hC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             0, 0,            0, 32'hC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 1, 32'h10,        0, 0,            0, 32'hC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 32'h100,      0, 32'hC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 1, 32'h100,       0, 0,            1, 32'h100));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 32'h104,      0, 32'h100));
        tbl.push_back(mk(0, 1, 0, 0, 0,            1, 1, 32'h104,       0, 0,            0, 32'h100));
        tbl.push_back(mk(1, 1, 1, 0, 0,            1, 0, 0,             0, 0,            0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 0,            0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 32'hFFFFFFFF, 1, 1, 0,             0, 0,            0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 32'hFFFFFFFC, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 1, 32'hFFFFFFFC,  0, 0,            1, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 1, 1, 0, 0,            1, 0, 0,             1, 0,            0, 32'hFFFFFFFC));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            reset = v.rst; PCWrite = v.pcw; IF_ID_Write = v.ifw; BranchTaken = v.br;
            BranchTarget = v.tgt; imem_ready = v.rdy; imem_rvalid = v.rv;
            imem_rdata = memf(v.rd_addr);
            #1;
            chk($sformatf("step%0d imem_req", i), {31'd0, imem_req}, {31'd0, v.e_req});
            if (v.e_req) chk($sformatf("step%0d imem_addr", i), imem_addr, v.e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("step%0d valid", i), {31'd0, IF_ID_Valid}, {31'd0, v.e_valid});
            chk($sformatf("step%0d pc", i), IF_ID_PC, v.e_pc);
            chk($sformatf("step%0d pc4", i), IF_ID_PC4, v.e_pc + 32'd4);
            chk($sformatf("step%0d instr", i), IF_ID_Instr, v.e_valid ? memf(v.e_pc) : NOP);
        end

        // Randomized phase: memory with random ready / latency, random stalls and branches
        @(negedge clk);
        reset = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0; BranchTaken = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        exp_pc = 32'd0; m_pc = 32'd0; m_pc4 = 32'd4; m_instr = NOP; m_valid = 1'b0;
        stale = 1'b0; have_buf = 1'b0; mem_busy = 1'b0; mem_lat = 0; mem_addr = 32'd0;
        prev_pending = 1'b0; prev_addr = 32'd0; deliveries = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            reset        = 1'b0;
            PCWrite      = ($urandom_range(0, 9) < 8);
            IF_ID_Write  = ($urandom_range(0, 3) != 0);
            BranchTaken  = ($urandom_range(0, 29) == 0);
            BranchTarget = $urandom;
            imem_ready   = ($urandom_range(0, 9) < 7);
            rv_now       = mem_busy && (mem_lat == 0);
            imem_rvalid  = rv_now;
            imem_rdata   = rv_now ? memf(mem_addr) : $urandom;
            #1;
            if (prev_pending) begin
                chk("rnd req_stable", {31'd0, imem_req}, 32'd1);
                chk("rnd addr_stable", imem_addr, prev_addr);
            end
            if (imem_req) begin
                chk("rnd one_outstanding", {31'd0, mem_busy}, 32'd0);
                if (imem_ready && !BranchTaken) chk("rnd fetch_addr", imem_addr, exp_pc);
            end
            acc      = imem_req && imem_ready;
            req_addr = imem_addr;
            prev_pending = imem_req && !imem_ready && !BranchTaken;
            prev_addr    = imem_addr;

            @(posedge clk);
            // kind: 0 = hold, 1 = bubble, 2 = deliver
            if (BranchTaken) begin
                kind = 1;
                if (rv_now) stale = 1'b0;
                else if (mem_busy || acc) stale = 1'b1;
                have_buf = 1'b0;
            end else begin
                kind = IF_ID_Write ? 1 : 0;
                if (rv_now) begin
                    if (stale) stale = 1'b0;
                    else if (IF_ID_Write) kind = 2;
                    else have_buf = 1'b1;
                end else if (have_buf && IF_ID_Write) begin
                    kind = 2;
                    have_buf = 1'b0;
                end
            end
            if (rv_now) mem_busy = 1'b0;
            else if (mem_busy) mem_lat--;
            if (acc) begin
                mem_busy = 1'b1;
                mem_addr = req_addr;
                mem_lat  = $urandom_range(0, 2);
            end

            if (kind == 2) begin
                m_pc = exp_pc; m_pc4 = exp_pc + 32'd4; m_instr = memf(exp_pc); m_valid = 1'b1;
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end else if (kind == 1) begin
                m_instr = NOP; m_valid = 1'b0;
            end
            if (BranchTaken) exp_pc = BranchTarget & 32'hFFFF_FFFC;

            #1;
            chk("rnd valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
            chk("rnd pc", IF_ID_PC, m_pc);
            chk("rnd pc4", IF_ID_PC4, m_pc4);
            chk("rnd instr", IF_ID_Instr, m_instr);
        end
        chk("rnd enough_deliveries", {31'd0, deliveries > 100}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-side consumer of the stall controls (PCWrite, IF_ID_Write) issued by the hazard detection unit.
- Owns the fetch PC, the instruction-memory request/response handshake (one outstanding request, variable latency) and the IF/ID pipeline register.
- Inserts NOP bubbles when no instruction is available.
- Redirects on taken branch and discards stale memory responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PCWrite  in  1  0 = do not issue a new fetch request.
- IF_ID_Write  in  1  0 = hold IF/ID contents.
- BranchTaken  in  1  redirect request from EX.
- BranchTarget  in  32  redirect address; bits[1:0] forced to 0.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address.
- imem_ready  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response data.
- IF_ID_PC  out  32  PC of the held instruction.
- IF_ID_PC4  out  32  IF_ID_PC + 4.
- IF_ID_Instr  out  32  held instruction, or NOP_INSTR.
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (sync, active-high; also mid-operation):
  - state=REQ, fetch_pc=RESET_PC, drop=0, req_hold=0, imem_req=0 in the reset cycle.
  - IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0.
  - An in-flight response arriving after reset is ignored. The memory model must not return it; the bench checks it is not delivered.
- States: REQ, WAIT, HOLD.
- Request issue:
  - imem_req = (state==REQ) && (PCWrite || req_hold); imem_addr = fetch_pc.
  - req_hold is set when imem_req=1 and imem_ready=0, and cleared on acceptance. Once asserted, imem_req and imem_addr stay stable until accepted.
  - REQ -> WAIT on imem_req && imem_ready.
- Response in WAIT:
  - imem_rvalid=1 and drop=1: clear drop, -> REQ.
  - imem_rvalid=1 and IF_ID_Write=1: IF/ID <= {fetch_pc, fetch_pc+4, imem_rdata, 1}; fetch_pc += 4; -> REQ.
  - imem_rvalid=1 and IF_ID_Write=0: latch rdata into buf; -> HOLD.
- HOLD: when IF_ID_Write=1, IF/ID <= {fetch_pc, fetch_pc+4, buf, 1}; fetch_pc += 4; -> REQ.
- Bubbles: if IF_ID_Write=1 and no delivery occurs this cycle, IF/ID <= {IF_ID_PC, IF_ID_PC4, NOP_INSTR, 0}.
- Stall: IF_ID_Write=0 holds all four IF/ID outputs unchanged.
- Latency and throughput:
  - Request acceptance to IF/ID update is 1 cycle after imem_rvalid.
  - Peak throughput is 1 instruction per 2 cycles (REQ/WAIT alternate).
- BranchTaken=1 has highest priority, above IF_ID_Write:
  - fetch_pc <= {BranchTarget[31:2], 2'b00}; IF/ID <= bubble.
  - REQ, not accepted: stay REQ, req_hold=0.
  - REQ, accepted this cycle: -> WAIT, drop=1.
  - WAIT, no rvalid: stay WAIT, drop=1.
  - WAIT, rvalid this cycle: response discarded, -> REQ.
  - HOLD: buf discarded, -> REQ.
- Arithmetic: fetch_pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Decomposition:
- Shared package holds the fetch state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2), NOP_INSTR and RESET_PC.
- One natural sub-module: if_id_register (PC, PC4, Instr, Valid). It has load, bubble and hold controls and reset to NOP.
- The FSM and PC logic stay in the top module.

Test Plan:
- Zero-wait memory (ready=1, rvalid the cycle after accept), rdata = PC-indexed → IF_ID_PC = 0,4,8,… at 1 per 2 cycles; Valid=1 on delivery cycles, bubble (NOP, Valid=0) in between.
- IF_ID_Write=0 and PCWrite=0 held for 3 cycles while the response at PC 0x8 arrives → state HOLD; IF/ID unchanged; imem_req=0. On release, Instr from PC 0x8 appears next cycle.
- imem_ready low for 4 cycles with PCWrite toggling → imem_req stays 1 and imem_addr stays 0x10 until accepted.
- BranchTaken with target 0x103 in WAIT; stale rvalid 2 cycles later → stale data never reaches IF/ID. Next request address is 0x100, and IF_ID_Instr = mem[0x100].
- Reset asserted in HOLD → next cycle Valid=0, Instr=0x13, first imem_addr=RESET_PC.
- fetch_pc=0xFFFF_FFFC delivery → IF_ID_PC4=0, next imem_addr=0.
